// File: rtl/alu_sweep_pkg.sv
// Shared types, constants and golden ALU function for the ALU sweep checker.
package alu_sweep_pkg;

    localparam int VEC_W    = 10;
    localparam int DATA_W   = 4;
    localparam int NUM_VECS = 1024;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // add/sub wrap modulo 16; carry and borrow are dropped
    function automatic logic [DATA_W-1:0] alu_golden_f(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [1:0]        op
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sweep_ctrl_golden.sv
// Purely combinational reference ALU wrapping the package golden function.
module alu_golden
    import alu_sweep_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_y
);

    assign o_y = alu_golden_f(i_a, i_b, i_op);

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Exhaustive {op,A,B} sweep of an external 4-bit ALU against a golden model.
// Optional macro ALU_SWEEP_STOP_ON_MISMATCH_EN ends the sweep at the first failure.
module alu_sweep_ctrl
    import alu_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [1:0]        alu_op,
    input  logic [3:0]        alu_result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              first_valid,
    output logic [9:0]        first_vec,
    output logic [3:0]        first_got,
    output logic [3:0]        first_exp
);

    localparam logic [3:0]       L_SETTLE = 4'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] L_LAST   = VEC_W'(NUM_VECS - 1);

    state_t              r_state;
    logic [VEC_W-1:0]    r_idx;
    logic [3:0]          r_settle;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_first_valid;
    logic [VEC_W-1:0]    r_first_vec;
    logic [DATA_W-1:0]   r_first_got;
    logic [DATA_W-1:0]   r_first_exp;

    logic [DATA_W-1:0]   w_exp;
    logic                w_mismatch;
    logic                w_last;
    logic                w_stop;
    logic [CNT_W-1:0]    w_cnt_inc;

    alu_golden u_golden (
        .i_a  (r_idx[7:4]),
        .i_b  (r_idx[3:0]),
        .i_op (r_idx[9:8]),
        .o_y  (w_exp)
    );

    assign w_mismatch = (alu_result != w_exp);
    assign w_last     = (r_idx == L_LAST);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef ALU_SWEEP_STOP_ON_MISMATCH_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_settle      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_cnt         <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_first_got   <= '0;
            r_first_exp   <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state       <= ST_DRIVE;
                            r_busy        <= 1'b1;
                            r_idx         <= '0;
                            r_pass        <= 1'b0;
                            r_cnt         <= '0;
                            r_first_valid <= 1'b0;
                            r_first_vec   <= '0;
                            r_first_got   <= '0;
                            r_first_exp   <= '0;
                        end
                    end
                    ST_DRIVE: begin
                        r_settle <= L_SETTLE;
                        r_state  <= (SETTLE_CYCLES == 0) ? ST_CHECK
                                                         : ST_WAIT;
                    end
                    ST_WAIT: begin
                        r_settle <= r_settle - 4'd1;
                        if (r_settle <= 4'd1) begin
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (w_mismatch) begin
                            r_cnt <= w_cnt_inc;
                            if (!r_first_valid) begin
                                r_first_valid <= 1'b1;
                                r_first_vec   <= r_idx;
                                r_first_got   <= alu_result;
                                r_first_exp   <= w_exp;
                            end
                        end
                        // pass folds in this cycle's compare result
                        if (w_last || w_stop) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (r_cnt == '0) && !w_mismatch;
                        end else begin
                            r_idx   <= r_idx + VEC_W'(1);
                            r_state <= ST_DRIVE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign alu_op         = r_idx[9:8];
    assign alu_a          = r_idx[7:4];
    assign alu_b          = r_idx[3:0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_count = r_cnt;
    assign first_valid    = r_first_valid;
    assign first_vec      = r_first_vec;
    assign first_got      = r_first_got;
    assign first_exp      = r_first_exp;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl: three instances with settle 1, 0 and 2.
module tb_alu_sweep_ctrl;

`ifdef ALU_SWEEP_STOP_ON_MISMATCH_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int CW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   passed;
    int   total;
    int   fmode;

    logic          st0, ab0, busy0, done0, pass0, fv0;
    logic [3:0]    a0, b0, res0, fgot0, fexp0;
    logic [1:0]    op0;
    logic [CW-1:0] cnt0;
    logic [9:0]    fvec0;

    logic          st1, ab1, busy1, done1, pass1, fv1;
    logic [3:0]    a1, b1, res1, fgot1, fexp1;
    logic [1:0]    op1;
    logic [CW-1:0] cnt1;
    logic [9:0]    fvec1, vec1;

    logic          st2, ab2, busy2, done2, pass2, fv2;
    logic [3:0]    a2, b2, res2, fgot2, fexp2;
    logic [1:0]    op2;
    logic [CW-1:0] cnt2;
    logic [9:0]    fvec2;

    logic [3:0]    p0a, p0b, p2a, p2b;

    assign vec1 = {op1, a1, b1};

    function automatic logic [3:0] ref_alu(input logic [1:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    always_comb begin
        res1 = ref_alu(op1, a1, b1);
        if (fmode == 1 && a1 == 4'd15 && op1 == 2'b01) res1 = a1;
        if (fmode == 2 && a1 == 4'd1 && op1 == 2'b00) res1 = a1 + b1 + 4'd1;
    end

    // two-register ALU: output lags the inputs by two clock edges
    always @(posedge clk) begin
        p0a <= ref_alu(op0, a0, b0);
        p0b <= p0a;
        p2a <= ref_alu(op2, a2, b2);
        p2b <= p2a;
    end
    assign res0 = p0b;
    assign res2 = p2b;

    alu_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(CW)) u_s0 (
        .clk(clk), .rst(rst), .start(st0), .abort(ab0),
        .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_result(res0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(cnt0),
        .first_valid(fv0), .first_vec(fvec0), .first_got(fgot0),
        .first_exp(fexp0));

    alu_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(CW)) u_s1 (
        .clk(clk), .rst(rst), .start(st1), .abort(ab1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(cnt1),
        .first_valid(fv1), .first_vec(fvec1), .first_got(fgot1),
        .first_exp(fexp1));

    alu_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(CW)) u_s2 (
        .clk(clk), .rst(rst), .start(st2), .abort(ab2),
        .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_result(res2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_count(cnt2),
        .first_valid(fv2), .first_vec(fvec2), .first_got(fgot2),
        .first_exp(fexp2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int k);
        case (k)
            0:       return busy0;
            2:       return busy2;
            default: return busy1;
        endcase
    endfunction

    function automatic logic done_of(input int k);
        case (k)
            0:       return done0;
            2:       return done2;
            default: return done1;
        endcase
    endfunction

    task automatic set_start(input int k, input logic v);
        case (k)
            0:       st0 = v;
            2:       st2 = v;
            default: st1 = v;
        endcase
    endtask

    task automatic sweep(input int k, output int nbusy, output int ndone,
                         output bit done_last);
        set_start(k, 1'b1);
        tick();
        set_start(k, 1'b0);
        nbusy = 0;
        ndone = 0;
        done_last = 1'b0;
        while (busy_of(k) && nbusy < 6000) begin
            nbusy++;
            if (done_of(k)) ndone++;
            done_last = done_of(k);
            tick();
        end
    endtask

    task automatic wait_vec1(input int target, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (vec1 == 10'(target)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok) $display("FAIL %s timeout got %0d exp %0d", name, vec1, target);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({op1, a1, b1} !== 10'd0) $display("FAIL reset_vec got %0h exp 0", vec1);
        else passed++;
        total++;
        if ({busy1, done1, pass1, fv1} !== 4'd0)
            $display("FAIL reset_flags got %b exp 0000", {busy1, done1, pass1, fv1});
        else passed++;
        total++;
        if ({cnt1, fvec1, fgot1, fexp1} !== '0)
            $display("FAIL reset_first got cnt %0d vec %0d exp 0", cnt1, fvec1);
        else passed++;
    endtask

    task automatic test_abort_start_same();
        ab1 = 1'b1;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        ab1 = 1'b0;
        tick();
        total++;
        if (busy1 !== 1'b0) $display("FAIL abort_start_idle busy got %b exp 0", busy1);
        else passed++;
    endtask

    task automatic test_clean_sweep();
        int nb, nd;
        bit dl;
        fmode = 0;
        sweep(1, nb, nd, dl);
        total++;
        if (nb !== 3073) $display("FAIL clean_busy_len got %0d exp 3073", nb);
        else passed++;
        total++;
        if (nd !== 1 || dl !== 1'b1)
            $display("FAIL clean_done got %0d last %b exp 1 last 1", nd, dl);
        else passed++;
        total++;
        if (pass1 !== 1'b1 || cnt1 !== 11'd0 || fv1 !== 1'b0)
            $display("FAIL clean_result got pass %b cnt %0d fv %b exp 1 0 0",
                     pass1, cnt1, fv1);
        else passed++;
        total++;
        if (vec1 !== 10'h3FF) $display("FAIL clean_hold got %0h exp 3ff", vec1);
        else passed++;
    endtask

    task automatic test_faulty_sweep();
        int nb, nd;
        bit dl;
        int exp_nb  = STOP ? 498 * 3 + 1 : 3073;
        int exp_cnt = STOP ? 1 : 15;
        int exp_vec = STOP ? 497 : 1023;
        fmode = 1;
        sweep(1, nb, nd, dl);
        total++;
        if (nb !== exp_nb) $display("FAIL fault_busy_len got %0d exp %0d", nb, exp_nb);
        else passed++;
        total++;
        if (pass1 !== 1'b0 || cnt1 !== 11'(exp_cnt))
            $display("FAIL fault_count got pass %b cnt %0d exp 0 %0d",
                     pass1, cnt1, exp_cnt);
        else passed++;
        total++;
        if (fv1 !== 1'b1 || fvec1 !== 10'd497 || fgot1 !== 4'd15 || fexp1 !== 4'd14)
            $display("FAIL fault_first got %b %0d %0d %0d exp 1 497 15 14",
                     fv1, fvec1, fgot1, fexp1);
        else passed++;
        total++;
        if (vec1 !== 10'(exp_vec)) $display("FAIL fault_hold got %0d exp %0d", vec1, exp_vec);
        else passed++;
    endtask

    task automatic test_abort();
        int nb, nd, dcount;
        bit dl;
        int exp_cnt = STOP ? 0 : 16;
        fmode = STOP ? 0 : 2;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        wait_vec1(100, "abort_reach");
        ab1 = 1'b1;
        tick();
        ab1 = 1'b0;
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL abort_idle got busy %b done %b exp 0 0", busy1, done1);
        else passed++;
        total++;
        if (vec1 !== 10'd100) $display("FAIL abort_hold got %0d exp 100", vec1);
        else passed++;
        total++;
        if (cnt1 !== 11'(exp_cnt) || pass1 !== 1'b0)
            $display("FAIL abort_cnt got %0d pass %b exp %0d 0", cnt1, pass1, exp_cnt);
        else passed++;
        total++;
        if (fvec1 !== (STOP ? 10'd0 : 10'd16) || fgot1 !== (STOP ? 4'd0 : 4'd2))
            $display("FAIL abort_first got %0d %0d", fvec1, fgot1);
        else passed++;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (done1 || busy1) dcount++;
            tick();
        end
        total++;
        if (dcount !== 0) $display("FAIL abort_no_done got %0d exp 0", dcount);
        else passed++;
        fmode = 0;
        sweep(1, nb, nd, dl);
        total++;
        if (nb !== 3073 || cnt1 !== 11'd0 || pass1 !== 1'b1 || fv1 !== 1'b0)
            $display("FAIL abort_restart got len %0d cnt %0d pass %b fv %b exp 3073 0 1 0",
                     nb, cnt1, pass1, fv1);
        else passed++;
    endtask

    task automatic test_start_ignored_rst();
        fmode = 0;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        wait_vec1(300, "restart_reach");
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        tick();
        total++;
        if (busy1 !== 1'b1 || vec1 < 10'd300 || vec1 > 10'd301)
            $display("FAIL start_ignored got busy %b vec %0d exp 1 300..301", busy1, vec1);
        else passed++;
        wait_vec1(600, "rst_reach");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({vec1, busy1, done1, pass1, fv1, cnt1, fvec1, fgot1, fexp1} !== '0)
            $display("FAIL rst_mid got vec %0d busy %b cnt %0d exp 0", vec1, busy1, cnt1);
        else passed++;
        tick();
        tick();
        total++;
        if (busy1 !== 1'b0 || vec1 !== 10'd0)
            $display("FAIL rst_idle got busy %b vec %0d exp 0 0", busy1, vec1);
        else passed++;
    endtask

    task automatic test_settle();
        int nb, nd;
        bit dl;
        int exp_nb = STOP ? 5 : 2049;
        sweep(0, nb, nd, dl);
        total++;
        if (nb !== exp_nb || nd !== 1) $display("FAIL s0_len got %0d exp %0d", nb, exp_nb);
        else passed++;
        total++;
        if (pass0 !== 1'b0 || cnt0 === 11'd0)
            $display("FAIL s0_detect got pass %b cnt %0d exp 0 nonzero", pass0, cnt0);
        else passed++;
        total++;
        if (fv0 !== 1'b1 || fvec0 !== 10'd1 || fgot0 !== 4'd0 || fexp0 !== 4'd1)
            $display("FAIL s0_first got %b %0d %0d %0d exp 1 1 0 1",
                     fv0, fvec0, fgot0, fexp0);
        else passed++;
        sweep(2, nb, nd, dl);
        total++;
        if (nb !== 4097 || nd !== 1) $display("FAIL s2_len got %0d exp 4097", nb);
        else passed++;
        total++;
        if (pass2 !== 1'b1 || cnt2 !== 11'd0 || fv2 !== 1'b0)
            $display("FAIL s2_result got pass %b cnt %0d fv %b exp 1 0 0",
                     pass2, cnt2, fv2);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        fmode  = 0;
        rst    = 1'b1;
        {st0, ab0, st1, ab1, st2, ab2} = '0;
        test_reset();
        test_abort_start_same();
        test_clean_sweep();
        test_faulty_sweep();
        test_abort();
        test_start_ignored_rst();
        test_settle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
